// File: rtl/counter_pkg.sv
// Shared types and limits for param_counter: direction and overflow-mode encodings
// plus the upper bound on counter width.
package counter_pkg;

  localparam int unsigned COUNTER_WIDTH_MAX = 32;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

endpackage

// File: rtl/param_counter.sv
// Up/down counter with terminal count MAX, wrap/saturate modes, load and single-cycle
// over/underflow pulses. Define PARAM_COUNTER_STICKY_EN to enable the sticky flag.
module param_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH = 4,
  parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             underflow,
  output logic             sticky_flag
);

  if (WIDTH < 1 || WIDTH > COUNTER_WIDTH_MAX) begin : g_bad_width
    $error("param_counter: WIDTH=%0d outside 1..%0d", WIDTH, COUNTER_WIDTH_MAX);
  end
  if (MAX < 1 || MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("param_counter: MAX=%0d outside 1..2**WIDTH-1", MAX);
  end

  localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  dir_e  dir_s;
  mode_e mode_s;
  assign dir_s  = dir_e'(dir);
  assign mode_s = mode_e'(mode);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (load) begin
      count_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (en) begin
      if (dir_s == DIR_UP) begin
        if (count_q == MAX_V) begin
          ovf_d   = 1'b1;
          count_d = (mode_s == MODE_SAT) ? MAX_V : '0;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q == '0) begin
          unf_d   = 1'b1;
          count_d = (mode_s == MODE_SAT) ? '0 : MAX_V;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

`ifdef PARAM_COUNTER_STICKY_EN
  logic sticky_q, sticky_d;

  // A new pulse on this edge takes precedence over a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (ovf_d || unf_d) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flag = sticky_q;
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_flag       = 1'b0;
`endif

endmodule
